// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through a
// request/acknowledge handshake on transmit_begin (active-low request)
// and transmit_over (transmitter idle flag, asynchronous to clk).
// Optional sticky overflow flag (ovf/ovf_clr) when UART_TXQ_OVF_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no byte handed over; pops when a byte is queued and the
//       | transmitter reports idle
// REQ   | byte popped into tx_data, transmit_begin low until the
//       | transmitter drops transmit_over (start acknowledged)
// BUSY  | frame in progress, waiting for transmit_over to return high
module uart_tx_queue #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          transmit_over,
    output logic [7:0]    tx_data,
    output logic          transmit_begin,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
`ifdef UART_TXQ_OVF_EN
    output logic          ovf,
    input  logic          ovf_clr,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_begin_q, tx_begin_d;
    logic            sync1_q;
    logic            over_s_q;
    logic            push;
    logic            pop;
    logic [7:0]      mem_q [DEPTH];

    // Two-flop synchronizer for the transmitter done flag; idle (1) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            over_s_q <= 1'b1;
        end else begin
            sync1_q  <= transmit_over;
            over_s_q <= sync1_q;
        end
    end

    // Next-state, pointer and occupancy logic; a full queue drops writes even on a pop cycle.
    always_comb begin
        state_d    = state_q;
        tx_begin_d = 1'b1;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        push       = wr_en && !full_q;

        case (state_q)
            ST_IDLE: begin
                if (!empty_q && over_s_q) begin
                    pop        = 1'b1;
                    state_d    = ST_REQ;
                    tx_begin_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (!over_s_q) begin
                    state_d = ST_BUSY;
                end else begin
                    tx_begin_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (over_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q];
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tx_data_q  <= 8'h00;
            tx_begin_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tx_data_q  <= tx_data_d;
            tx_begin_q <= tx_begin_d;
        end
    end

    // Storage array; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a dropped write beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign tx_data        = tx_data_q;
    assign transmit_begin = tx_begin_q;
    assign full           = full_q;
    assign empty          = empty_q;
    assign count          = count_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
